// File: rtl/rs232_avm_slave.sv
// ============================================================================
// Module   : rs232_avm_slave
// Purpose  : Avalon-MM slave 8N1 UART with one-byte RX/TX buffers.
//            Define RS232_LOOPBACK_EN to feed RX from the internal o_txd.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232_avm_slave #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic        i_rxd,
    output logic        o_txd
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic          ack_r;
    logic          rx_ok;
    logic          tx_ok;
    logic          fe;
    logic          ovr;
    logic [7:0]    rx_byte;
    logic [31:0]   status_word;
    logic          rx_rd_done;
    logic          st_rd_done;
    logic          tx_load;

    state_t        tx_state;
    logic [TW-1:0] tx_timer;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    state_t        rx_state;
    logic [TW-1:0] rx_timer;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_src;
    logic          rx_meta;
    logic          rx_sync;

    assign avm_waitrequest = ~ack_r;
    assign status_word     = {24'b0, rx_ok, tx_ok, 2'b0, ovr, fe, 2'b0};
    assign rx_rd_done      = ack_r & avm_read  & (avm_address == 5'd0);
    assign st_rd_done      = ack_r & avm_read  & (avm_address == 5'd8);
    assign tx_load         = ack_r & avm_write & (avm_address == 5'd4) & tx_ok;

`ifdef RS232_LOOPBACK_EN
    assign rx_src = o_txd;
    logic unused_pins;
    assign unused_pins = &{1'b0, i_rxd, avm_writedata[31:8]};
`else
    assign rx_src = i_rxd;
    logic unused_pins;
    assign unused_pins = &{1'b0, avm_writedata[31:8]};
`endif

    // Read data is captured on the first request cycle, then held.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            ack_r        <= 1'b0;
            avm_readdata <= 32'd0;
        end else begin
            ack_r <= (avm_read | avm_write) & ~ack_r;
            if (avm_read && !ack_r) begin
                case (avm_address)
                    5'd0:    avm_readdata <= {24'b0, rx_byte};
                    5'd8:    avm_readdata <= status_word;
                    default: avm_readdata <= 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            tx_state <= S_IDLE;
            tx_timer <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            tx_ok    <= 1'b1;
            o_txd    <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    o_txd    <= 1'b1;
                    tx_timer <= '0;
                    tx_bit   <= 3'd0;
                    if (tx_load) begin
                        tx_state <= S_START;
                        tx_shift <= avm_writedata[7:0];
                        tx_ok    <= 1'b0;
                        o_txd    <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx_state <= S_DATA;
                        o_txd    <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_bit   <= 3'd0;
                            tx_state <= S_STOP;
                            o_txd    <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            o_txd    <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx_state <= S_IDLE;
                        tx_ok    <= 1'b1;
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
        end
    end

    // Bus clears come first so a same-edge receive event overrides them.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rx_state <= S_IDLE;
            rx_timer <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            rx_byte  <= 8'd0;
            rx_ok    <= 1'b0;
            fe       <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (rx_rd_done) rx_ok <= 1'b0;
            if (st_rd_done) begin
                fe  <= 1'b0;
                ovr <= 1'b0;
            end
            case (rx_state)
                S_IDLE: begin
                    rx_timer <= '0;
                    rx_bit   <= 3'd0;
                    if (!rx_sync) rx_state <= S_START;
                end
                S_START: begin
                    if (rx_timer == HALF_LAST) begin
                        rx_timer <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_bit   <= 3'd0;
                            rx_state <= S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_state <= S_IDLE;
                        if (rx_sync) begin
                            rx_byte <= rx_shift;
                            rx_ok   <= 1'b1;
                            if (rx_ok && !rx_rd_done) ovr <= 1'b1;
                        end else begin
                            fe <= 1'b1;
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs232_avm_slave.sv
// ============================================================================
// Module   : tb_rs232_avm_slave
// Purpose  : Scoreboard bench for rs232_avm_slave at 8 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs232_avm_slave;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  avm_address = 5'd0;
    logic        avm_read = 1'b0;
    logic [31:0] avm_readdata;
    logic        avm_write = 1'b0;
    logic [31:0] avm_writedata = 32'd0;
    logic        avm_waitrequest;
    logic        rxd = 1'b1;
    logic        txd;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    rs232_avm_slave #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk        (clk),
        .avm_rst_n      (rst_n),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .i_rxd          (rxd),
        .o_txd          (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Read-data monitor: compares whenever the slave accepts a read.
    always @(negedge clk) begin
        if (avm_read && !avm_waitrequest) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got 0x%0h expected no read", avm_readdata);
            end else begin
                check(name_q.pop_front(), avm_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp,
                            input string nm, input bit chk_lat);
        int n;
        bit got;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        avm_address = a;
        avm_read    = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (!avm_waitrequest) got = 1'b1;
        end
        if (!got) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        if (chk_lat) check({nm, "_latency"}, n, 32'd1);
        @(posedge clk);
        #1 avm_read = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input string nm);
        int n;
        bit got;
        @(negedge clk);
        avm_address   = a;
        avm_writedata = d;
        avm_write     = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (!avm_waitrequest) got = 1'b1;
        end
        check({nm, "_latency"}, n, 32'd1);
        @(posedge clk);
        #1 avm_write = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopbit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stopbit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic mid_tx_reset();
        bus_write(5'd4, 32'h3C, "wr_pre_reset");
        repeat (20) @(posedge clk);
        #2;
        check("txd_low_before_reset", {31'b0, txd}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("reset_txd", {31'b0, txd}, 32'd1);
        check("reset_waitrequest", {31'b0, avm_waitrequest}, 32'd1);
        check("reset_readdata", avm_readdata, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        bus_read(5'd8, 32'h40, "status_after_reset", 1'b0);
        bus_read(5'd0, 32'h00, "rx_after_reset", 1'b0);
    endtask

    initial begin
        logic [9:0] frame;
        frame = 10'b10_0011_1100 << 1;
        frame = {1'b1, 8'h3C, 1'b0};
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        mid_tx_reset();

`ifdef RS232_LOOPBACK_EN
        bus_write(5'd4, 32'h7E, "wr_loop");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 3 == 0) rxd = ~rxd;
        end
        rxd = 1'b1;
        bus_read(5'd8, 32'hC0, "loop_status", 1'b0);
        bus_read(5'd0, 32'h7E, "loop_rx", 1'b0);
        bus_read(5'd8, 32'h40, "loop_status_after", 1'b0);
`else
        // TX frame 0x3C with a mid-frame status read and ignored write.
        bus_write(5'd4, 32'h3C, "wr_tx");
        fork
            begin
                repeat (3) @(posedge clk);
                for (int k = 0; k < 10; k++) begin
                    #1 check($sformatf("tx_bit%0d", k), {31'b0, txd}, {31'b0, frame[k]});
                    repeat (CPB) @(posedge clk);
                end
            end
            begin
                repeat (20) @(posedge clk);
                bus_read(5'd8, 32'h00, "status_mid_tx", 1'b0);
                bus_write(5'd4, 32'hFF, "wr_ignored");
                bus_read(5'd4, 32'h00, "tx_addr_reads_zero", 1'b0);
            end
        join
        bus_read(5'd8, 32'h40, "status_after_tx", 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1 check("txd_idle_after_tx", {31'b0, txd}, 32'd1);

        send_byte(8'hA5, 1'b1);
        bus_read(5'd8, 32'hC0, "status_rx_a5", 1'b0);
        bus_read(5'd0, 32'hA5, "rx_a5", 1'b1);
        bus_read(5'd8, 32'h40, "status_after_rx", 1'b0);
        bus_read(5'd12, 32'h00, "unmapped_reads_zero", 1'b0);

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        bus_read(5'd8, 32'hC8, "status_overrun", 1'b0);
        bus_read(5'd0, 32'h22, "rx_overrun", 1'b0);
        bus_read(5'd8, 32'h40, "status_after_ovr", 1'b0);

        send_byte(8'h55, 1'b0);
        bus_read(5'd8, 32'h44, "status_framing", 1'b0);
        bus_read(5'd8, 32'h40, "status_fe_cleared", 1'b0);

        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        bus_read(5'd8, 32'h40, "status_glitch", 1'b0);
        bus_read(5'd0, 32'h22, "rx_byte_kept", 1'b0);
`endif

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            check("scoreboard_drained", exp_q.size(), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
